rv_alu_arb: RTL and testbench

RV_ALU_ARB -- requirements
Module: rv_alu_arb

---
 rtl/rv_alu_arb.sv | 137 +++++++++++++
 tb/tb_rv_alu_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_arb.sv
// rv_alu_arb: two-requester front end for a single shared ALU.
//
// A granted requester's operands and control code are latched and driven to
// the ALU. The ALU result and zero flag are captured one cycle later and held
// for the owning requester until that requester consumes them. Only one
// operation is in flight at a time.
//
// Configuration macro RV_ALU_ARB_RR_EN:
//   defined   - round-robin grant when both requesters are valid.
//   undefined - fixed priority, requester 0 wins.
//
// Ports:
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_reqN_valid / o_reqN_ready  request handshake, N = 0,1
//   i_reqN_src_a/_src_b/_ctrl    request operands and ALU control code
//   o_alu_src_a/_src_b/_ctrl     operands to the shared ALU
//   i_alu_result, i_alu_zero     combinational ALU outputs
//   o_rspN_valid / i_rspN_ready  response handshake, N = 0,1
//   o_rsp_result, o_rsp_zero     captured result, shared by both requesters
//   o_busy                       an operation is in flight
module rv_alu_arb (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_src_a,
    input  logic [31:0] i_req0_src_b,
    input  logic [4:0]  i_req0_ctrl,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_src_a,
    input  logic [31:0] i_req1_src_b,
    input  logic [4:0]  i_req1_ctrl,
    output logic        o_req1_ready,
    output logic [31:0] o_alu_src_a,
    output logic [31:0] o_alu_src_b,
    output logic [4:0]  o_alu_ctrl,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_zero,
    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,
    output logic [31:0] o_rsp_result,
    output logic        o_rsp_zero,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   grant;      // requester selected while idle: 0 or 1
    logic   hs0, hs1;
    logic   owner_rsp_ready;

`ifdef RV_ALU_ARB_RR_EN
    logic   last_winner;  // resets to 1 so the first contended grant goes to 0
`endif

    always_comb begin
        grant = 1'b0;
`ifdef RV_ALU_ARB_RR_EN
        if (i_req0_valid && i_req1_valid)
            grant = ~last_winner;
        else
            grant = i_req1_valid;
`else
        grant = i_req1_valid && !i_req0_valid;
`endif
    end

    assign o_req0_ready = (state == IDLE) && !grant && i_req0_valid;
    assign o_req1_ready = (state == IDLE) &&  grant && i_req1_valid;
    assign hs0          = i_req0_valid && o_req0_ready;
    assign hs1          = i_req1_valid && o_req1_ready;

    // Only the owner's consume strobe matters; the other one is ignored.
    assign owner_rsp_ready = owner ? i_rsp1_ready : i_rsp0_ready;

    assign o_rsp0_valid = (state == RESP) && !owner;
    assign o_rsp1_valid = (state == RESP) &&  owner;
    assign o_busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs0 || hs1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (owner_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_alu_src_a  <= '0;
            o_alu_src_b  <= '0;
            o_alu_ctrl   <= '0;
            owner        <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_zero   <= 1'b0;
        end else begin
            if (hs0) begin
                o_alu_src_a <= i_req0_src_a;
                o_alu_src_b <= i_req0_src_b;
                o_alu_ctrl  <= i_req0_ctrl;
                owner       <= 1'b0;
            end else if (hs1) begin
                o_alu_src_a <= i_req1_src_a;
                o_alu_src_b <= i_req1_src_b;
                o_alu_ctrl  <= i_req1_ctrl;
                owner       <= 1'b1;
            end
            if (state == EXEC) begin
                o_rsp_result <= i_alu_result;
                o_rsp_zero   <= i_alu_zero;
            end
        end
    end

`ifdef RV_ALU_ARB_RR_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            last_winner <= 1'b1;
        else if (hs0 || hs1)
            last_winner <= hs1;
    end
`endif

endmodule

// File: tb/tb_rv_alu_arb.sv
// tb_rv_alu_arb: scoreboard bench for rv_alu_arb. Stimulus pushes the
// expected response when a request is accepted; a negedge monitor checks
// grants, busy and responses against the queue front.
module tb_rv_alu_arb;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic [31:0] i_req0_src_a = '0, i_req0_src_b = '0;
    logic [31:0] i_req1_src_a = '0, i_req1_src_b = '0;
    logic [4:0]  i_req0_ctrl = '0, i_req1_ctrl = '0;
    logic        o_req0_ready, o_req1_ready;
    logic [31:0] o_alu_src_a, o_alu_src_b;
    logic [4:0]  o_alu_ctrl;
    logic [31:0] i_alu_result;
    logic        i_alu_zero;
    logic        o_rsp0_valid, o_rsp1_valid;
    logic        i_rsp0_ready = 1'b0, i_rsp1_ready = 1'b0;
    logic [31:0] o_rsp_result;
    logic        o_rsp_zero;
    logic        o_busy;

    typedef struct {
        bit          owner;
        logic [31:0] res;
        bit          zero;
        time         t_acc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   last = 1'b1;     // model of the last winner; reset value 1

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return a << b[4:0];
            5'd6:    return {31'd0, a < b};
            default: return a;
        endcase
    endfunction

    assign i_alu_result = alu(o_alu_ctrl, o_alu_src_a, o_alu_src_b);
    assign i_alu_zero   = (i_alu_result == 32'd0);

    rv_alu_arb dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req0_valid(i_req0_valid), .i_req0_src_a(i_req0_src_a),
        .i_req0_src_b(i_req0_src_b), .i_req0_ctrl(i_req0_ctrl), .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_src_a(i_req1_src_a),
        .i_req1_src_b(i_req1_src_b), .i_req1_ctrl(i_req1_ctrl), .o_req1_ready(o_req1_ready),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_ctrl(o_alu_ctrl),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero),
        .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
        .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_zero(o_rsp_zero), .o_busy(o_busy)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Monitor: compare DUT outputs to the model on every falling edge.
    bit eb, ev0, ev1, g, er0, er1;
    always @(negedge i_clk) begin
        if (!i_reset) begin
            eb  = (q.size() != 0);
            // Response becomes visible two edges after acceptance.
            ev0 = eb && !q[0].owner && ($time - q[0].t_acc) > 10;
            ev1 = eb &&  q[0].owner && ($time - q[0].t_acc) > 10;
            chk("busy", {31'd0, o_busy}, {31'd0, eb});
            chk("rsp0_valid", {31'd0, o_rsp0_valid}, {31'd0, ev0});
            chk("rsp1_valid", {31'd0, o_rsp1_valid}, {31'd0, ev1});
            if (ev0 || ev1) begin
                chk("rsp_result", o_rsp_result, q[0].res);
                chk("rsp_zero", {31'd0, o_rsp_zero}, {31'd0, q[0].zero});
            end
`ifdef RV_ALU_ARB_RR_EN
            g = (i_req0_valid && i_req1_valid) ? ~last : i_req1_valid;
`else
            g = i_req1_valid && !i_req0_valid;
`endif
            er0 = !eb && i_req0_valid && !g;
            er1 = !eb && i_req1_valid &&  g;
            chk("req0_ready", {31'd0, o_req0_ready}, {31'd0, er0});
            chk("req1_ready", {31'd0, o_req1_ready}, {31'd0, er1});
            if ((ev0 && i_rsp0_ready) || (ev1 && i_rsp1_ready)) begin
                last = q[0].owner;
                void'(q.pop_front());
            end
        end
    end

    // One clock: detect a handshake before the edge, push its expected result at the edge.
    task automatic cycle();
        bit h0, h1;
        logic [31:0] r;
        @(negedge i_clk);
        h0 = i_req0_valid && o_req0_ready;
        h1 = i_req1_valid && o_req1_ready;
        @(posedge i_clk);
        if (h0) begin
            r = alu(i_req0_ctrl, i_req0_src_a, i_req0_src_b);
            q.push_back('{1'b0, r, r == 32'd0, $time});
        end
        if (h1) begin
            r = alu(i_req1_ctrl, i_req1_src_a, i_req1_src_b);
            q.push_back('{1'b1, r, r == 32'd0, $time});
        end
        #1;
    endtask

    task automatic set_req(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] c0,
                           input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] c1);
        i_req0_valid = v0; i_req0_src_a = a0; i_req0_src_b = b0; i_req0_ctrl = c0;
        i_req1_valid = v1; i_req1_src_a = a1; i_req1_src_b = b1; i_req1_ctrl = c1;
    endtask

    initial begin
        // Reset state.
        #2;
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_rsp0_valid", {31'd0, o_rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'd0, o_rsp1_valid}, 32'd0);
        chk("reset_alu_src_a", o_alu_src_a, 32'd0);
        chk("reset_alu_src_b", o_alu_src_b, 32'd0);
        chk("reset_alu_ctrl", {27'd0, o_alu_ctrl}, 32'd0);
        chk("reset_rsp_result", o_rsp_result, 32'd0);
        chk("reset_rsp_zero", {31'd0, o_rsp_zero}, 32'd0);
        @(posedge i_clk); #1 i_reset = 1'b0;

        // Single op: 5 + 3.
        i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
        set_req(1, 32'd5, 32'd3, 5'd0, 0, '0, '0, '0);
        cycle();
        set_req(0, '0, '0, '0, 0, '0, '0, '0);
        chk("alu_src_a_after_accept", o_alu_src_a, 32'd5);
        repeat (4) cycle();

        // Contention: SUB 7-7 on req0, XOR 1^2 on req1.
        set_req(1, 32'd7, 32'd7, 5'd1, 1, 32'd1, 32'd2, 5'd4);
        repeat (12) cycle();
        set_req(0, '0, '0, '0, 0, '0, '0, '0);
        repeat (3) cycle();

        // Backpressure on req1, with req0 pending and i_rsp0_ready toggling.
        i_rsp1_ready = 1'b0;
        set_req(0, '0, '0, '0, 1, 32'h1234, 32'h0F0F, 5'd2);
        cycle();
        set_req(1, 32'd9, 32'd1, 5'd0, 0, '0, '0, '0);
        for (int i = 0; i < 7; i++) begin
            i_rsp0_ready = i[0];
            cycle();
        end
        i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
        repeat (5) cycle();
        set_req(0, '0, '0, '0, 0, '0, '0, '0);
        repeat (2) cycle();

        // Reset during EXEC aborts the operation.
        set_req(1, 32'd10, 32'd20, 5'd0, 0, '0, '0, '0);
        cycle();
        set_req(0, '0, '0, '0, 0, '0, '0, '0);
        #2 i_reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_rsp0_valid", {31'd0, o_rsp0_valid}, 32'd0);
        chk("abort_rsp1_valid", {31'd0, o_rsp1_valid}, 32'd0);
        q.delete();
        last = 1'b1;
        #3 i_reset = 1'b0;
        repeat (3) cycle();
        set_req(0, '0, '0, '0, 1, 32'd100, 32'd1, 5'd1);
        cycle();
        set_req(0, '0, '0, '0, 0, '0, '0, '0);
        repeat (4) cycle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            set_req($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
                    5'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
                    5'($urandom_range(0, 7)));
            i_rsp0_ready = $urandom_range(0, 9) < 6;
            i_rsp1_ready = $urandom_range(0, 9) < 6;
            cycle();
        end

        // Drain with a bounded wait.
        set_req(0, '0, '0, '0, 0, '0, '0, '0);
        i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
        chk("drain_queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
